ps2_keyboard_ctrl: RTL

Second-generation PS/2 keyboard controller. It deserialises raw PS/2 frames in the system clock domain, with no PS/2-clocked logic, and checks parity and timeout. It decodes the E0 (extended) and F0 (break) prefixes, maintains a parametrised key-state bitmap, and queues every key event in a FIFO. It sits on the system bus as a read-only peripheral using the existing ack-driven 4-state bus handshake, and never stalls the bus.

---
 rtl/ps2_pkg.sv | 43 ++++
 rtl/ps2_keyboard_ctrl_frame_rx.sv | 87 ++++++++
 rtl/ps2_keyboard_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, key table and types for the PS/2 keyboard controller.
package ps2_pkg;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BREAK = 8'hF0;

  localparam logic [3:0] REG_BITMAP = 4'd0;
  localparam logic [3:0] REG_FIFO   = 4'd1;
  localparam logic [3:0] REG_STATUS = 4'd2;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } key_evt_t;

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {BUS_WAIT_FOR_ACK, BUS_READ_WAIT, BUS_READ_DATA, BUS_FINISH} bus_state_t;

  // Returns {present, ext, code}; present=0 past the end of the table.
  function automatic logic [9:0] key_entry(input int idx);
    case (idx)
      0:       key_entry = 10'h224;  // E
      1:       key_entry = 10'h21D;  // W
      2:       key_entry = 10'h21C;  // A
      3:       key_entry = 10'h21B;  // S
      4:       key_entry = 10'h223;  // D
      5:       key_entry = 10'h26C;  // KP7
      6:       key_entry = 10'h275;  // KP8
      7:       key_entry = 10'h26B;  // KP4
      8:       key_entry = 10'h273;  // KP5
      9:       key_entry = 10'h274;  // KP6
      10:      key_entry = 10'h375;  // Up
      11:      key_entry = 10'h36B;  // Left
      12:      key_entry = 10'h372;  // Down
      13:      key_entry = 10'h374;  // Right
      14:      key_entry = 10'h229;  // Space
      15:      key_entry = 10'h25A;  // Enter
      default: key_entry = 10'h000;
    endcase
  endfunction

endpackage

// File: rtl/ps2_keyboard_ctrl_frame_rx.sv
// PS/2 frame receiver in the system clock domain: synchroniser, falling-edge
// detect, start/data/parity/stop sequencing and inactivity timeout.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err,
  output logic       rx_busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, dat_sync;
  logic          clk_prev;
  logic          fall;
  rx_state_t     state;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          parity;
  logic [TW-1:0] timer;

  assign fall    = clk_prev && !clk_sync[1];
  assign rx_busy = (state != RX_IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // Idle-high reset values so leaving reset never fakes a falling edge.
      clk_sync   <= 2'b11;
      dat_sync   <= 2'b11;
      clk_prev   <= 1'b1;
      state      <= RX_IDLE;
      bit_idx    <= '0;
      shift      <= '0;
      parity     <= 1'b0;
      timer      <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_sync   <= {clk_sync[0], ps2_clk};
      dat_sync   <= {dat_sync[0], ps2_data};
      clk_prev   <= clk_sync[1];
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (state == RX_IDLE || fall) timer <= '0;
      else                          timer <= timer + 1'b1;

      case (state)
        RX_IDLE: if (fall && !dat_sync[1]) begin
          state   <= RX_DATA;
          bit_idx <= '0;
        end
        RX_DATA: if (fall) begin
          shift   <= {dat_sync[1], shift[7:1]};
          bit_idx <= bit_idx + 1'b1;
          if (bit_idx == 3'd7) state <= RX_PARITY;
        end
        RX_PARITY: if (fall) begin
          parity <= dat_sync[1];
          state  <= RX_STOP;
        end
        RX_STOP: if (fall) begin
          state <= RX_IDLE;
          if (dat_sync[1] && (^{shift, parity})) begin
            rx_byte    <= shift;
            byte_valid <= 1'b1;
          end else begin
            frame_err  <= 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase

      // A stalled partial frame is silently dropped, not counted as an error.
      if (state != RX_IDLE && !fall && timer == TW'(TIMEOUT_CYCLES - 1))
        state <= RX_IDLE;
    end
  end

endmodule

// File: rtl/ps2_keyboard_ctrl.sv
// PS/2 keyboard controller: prefix decoding, key-state bitmap, event FIFO and
// a read-only register window behind the ack-driven 4-state bus handshake.
module ps2_keyboard_ctrl
  import ps2_pkg::*;
#(
  parameter int BUS_WIDTH      = 32,
  parameter int CTRL_WIDTH     = 8,
  parameter int NUM_KEYS       = 16,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  input  logic                  ack,
  input  logic [BUS_WIDTH-1:0]  bus_in,
  output logic [BUS_WIDTH-1:0]  bus_out,
  output logic [CTRL_WIDTH-1:0] ctrl_out,
  output logic [4:0]            debug_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]          rx_byte;
  logic                byte_valid, frame_err, rx_busy;
  logic                ext_flag, brk_flag;
  logic [NUM_KEYS-1:0] bitmap;
  logic [7:0]          err_cnt;
  logic                overflow;
  key_evt_t            fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       fifo_cnt;
  bus_state_t          bus_state;
  logic [3:0]          addr;
  logic [BUS_WIDTH-1:0] rd_data;
  logic                fifo_empty, fifo_full, push, do_push, pop;
  key_evt_t            evt;
  logic                unused_bus;

  ps2_frame_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (frame_err),
    .rx_busy    (rx_busy)
  );

  assign unused_bus = ^bus_in[BUS_WIDTH-1:4];
  assign ctrl_out   = '0;
  assign evt        = {brk_flag, ext_flag, rx_byte};
  assign push       = byte_valid && rx_byte != PS2_EXT && rx_byte != PS2_BREAK;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == CW'(FIFO_DEPTH));
  assign pop        = (bus_state == BUS_READ_DATA) && (addr == REG_FIFO) && !fifo_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push    = push && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      bitmap   <= '0;
      err_cnt  <= '0;
    end else if (frame_err) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      if (err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end else if (byte_valid) begin
      if (rx_byte == PS2_EXT) ext_flag <= 1'b1;
      else if (rx_byte == PS2_BREAK) brk_flag <= 1'b1;
      else begin
        for (int i = 0; i < NUM_KEYS; i++)
          if (key_entry(i) == {1'b1, ext_flag, rx_byte}) bitmap[i] <= !brk_flag;
        ext_flag <= 1'b0;
        brk_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= evt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
      else if (!do_push && pop) fifo_cnt <= fifo_cnt - 1'b1;
      if (bus_state == BUS_READ_DATA && addr == REG_STATUS) overflow <= 1'b0;
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr)
      REG_BITMAP: rd_data[NUM_KEYS-1:0] = bitmap;
      REG_FIFO: if (!fifo_empty) begin
        rd_data[31]  = 1'b1;
        rd_data[9:0] = fifo_mem[rd_ptr];
      end
      REG_STATUS: begin
        rd_data[31]      = overflow;
        rd_data[16 +: CW] = fifo_cnt;
        rd_data[7:0]     = err_cnt;
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus_state <= BUS_WAIT_FOR_ACK;
      addr      <= '0;
      bus_out   <= '0;
      debug_out <= '0;
    end else begin
      debug_out <= {frame_err, overflow, fifo_empty, rx_busy, ext_flag};
      case (bus_state)
        BUS_WAIT_FOR_ACK: begin
          addr <= bus_in[3:0];
          if (ack) bus_state <= BUS_READ_WAIT;
        end
        BUS_READ_WAIT: begin
          bus_out   <= rd_data;
          bus_state <= BUS_READ_DATA;
        end
        BUS_READ_DATA: bus_state <= BUS_FINISH;
        default:       bus_state <= BUS_WAIT_FOR_ACK;
      endcase
    end
  end

endmodule
